// File: rtl/seq_match_pkg.sv
// Shared types and default sizes for the programmable serial-pattern match controller.
package seq_match_pkg;
    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill tracking and masked pattern compare; hit is combinational
// on the bit being presented this cycle.
module seq_match_core
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               in,
    input  logic               in_valid,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);
    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;

    // Newest bit sits at position 0, matching the pattern's last-received bit.
    assign window = {hist_q, in};
    assign mask   = ~({MAX_LEN{1'b1}} << len);
    assign hit    = enable && in_valid && (fill_q >= (len - LEN_W'(1)))
                    && ((window & mask) == (pattern & mask));

    always_comb begin
        fill_d = fill_q;
        if (hit && !overlap) begin
            fill_d = '0;
        end else if (fill_q < len) begin
            fill_d = fill_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (enable && in_valid) begin
            hist_q <= window[MAX_LEN-2:0];
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/seq_match_ctrl.sv
// Arms, runs and terminates a programmable serial-pattern detector; counts matches
// toward a target (or free-runs) and reports busy/done/err status.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               err
);
    state_e             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               busy_q;
    logic               match_q;
    logic               done_q;
    logic               err_q;
    logic               len_ok;
    logic               start_ok;
    logic               hit;

    assign len_ok   = (int'(cfg_len) >= 2) && (int'(cfg_len) <= MAX_LEN);
    assign start_ok = start && !abort && len_ok && (state_q != ARMED);
    // Saturating increment; only reachable in free-run since a nonzero target stops first.
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok),
        .enable   (state_q == ARMED),
        .in       (in),
        .in_valid (in_valid),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            match_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ARMED: begin
                    // Abort takes priority and discards any hit presented this cycle.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (hit) begin
                        match_q <= 1'b1;
                        cnt_q   <= cnt_d;
                        if ((tgt_q != '0) && (cnt_d == tgt_q)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end else if (start_ok) begin
                        pat_q   <= cfg_pattern;
                        len_q   <= cfg_len;
                        ovl_q   <= cfg_overlap;
                        tgt_q   <= cfg_target;
                        cnt_q   <= '0;
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign match       = match_q;
    assign match_count = cnt_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule
